// File: rtl/gg_cell.sv
// gg_cell: Givens-generation (vectoring-mode CORDIC) cell at the QR array diagonal.
// Holds the diagonal element, annihilates each incoming sub-diagonal sample, and
// streams the micro-rotation direction bits so rotation cells can replay them.
// Optional feature macro: GG_OVF_FLAG_EN builds a sticky overrun flag on err_o;
// without it err_o is tied low and overrun samples are silently dropped.
module gg_cell #(
  parameter int D_WIDTH    = 4,
  parameter int DATA_WIDTH = 20,
  parameter int ROWS       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic                         valid_i,
  input  logic                         clr_i,
  output logic [D_WIDTH-1:0]           d_o,
  output logic                         rotates_o,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] r_o,
  output logic                         done_o,
  output logic                         busy_o,
  output logic                         err_o
);

  // Handshake: x_i is taken on a cycle with valid_i high only in EMPTY or READY.
  // There is no ready output; busy_o high (ROT/SCALE) or DONE means valid_i is
  // dropped. On the output side valid_o frames the first of the rotates_o cycles,
  // and the receiver has no way to stall the stream.

  localparam int N_ITER = 12;
  localparam int N_GRP  = N_ITER / D_WIDTH;
  localparam int CNT_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam int SH_W   = $clog2(N_ITER);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_GRP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS);
  // CORDIC gain compensation, 0.6064 in Q10.10.
  localparam logic signed [DATA_WIDTH-1:0] K_Q = DATA_WIDTH'(621);

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_READY = 3'd1,
    ST_ROT   = 3'd2,
    ST_SCALE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ROW_W-1:0]               row_cnt_q, row_cnt_d, row_inc;
  logic signed [DATA_WIDTH-1:0]   x_ff_q, x_ff_d;
  logic signed [DATA_WIDTH-1:0]   y_ff_q, y_ff_d;
  logic [D_WIDTH-1:0]             d_q, d_d;
  logic                           rotates_q, rotates_d;
  logic                           valid_q, valid_d;
  logic                           done_q, done_d;
  logic signed [DATA_WIDTH-1:0]   r_q, r_d;

  logic signed [DATA_WIDTH-1:0]   rot_x, rot_y;
  logic [D_WIDTH-1:0]             rot_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   scaled;

  // Chain of D_WIDTH micro-rotations for the current group; the first group
  // takes the fresh sample as y, later groups continue from y_ff.
  always_comb begin : cordic_chain
    logic signed [DATA_WIDTH-1:0] xv, yv, xs, ys;
    logic [SH_W-1:0]              sh;
    xv    = x_ff_q;
    yv    = (state_q == ST_READY) ? x_i : y_ff_q;
    rot_d = '0;
    for (int k = 0; k < D_WIDTH; k++) begin
      sh       = SH_W'(int'(cnt_q) * D_WIDTH + k);
      xs       = xv >>> sh;
      ys       = yv >>> sh;
      rot_d[k] = xv[DATA_WIDTH-1] ^ yv[DATA_WIDTH-1];
      if (rot_d[k]) begin
        xv = xv - ys;
        yv = yv + xs;
      end else begin
        xv = xv + ys;
        yv = yv - xs;
      end
    end
    rot_x = xv;
    rot_y = yv;
  end

  // Gain compensation: full-width product, Q10.10 realignment, wrap to DATA_WIDTH.
  assign prod    = (2*DATA_WIDTH)'(x_ff_q) * (2*DATA_WIDTH)'(K_Q);
  assign scaled  = DATA_WIDTH'(prod >>> 10);
  assign row_inc = row_cnt_q + ROW_W'(1);

  // Next-state and datapath update; strobes default low so they pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_cnt_d = row_cnt_q;
    x_ff_d    = x_ff_q;
    y_ff_d    = y_ff_q;
    d_d       = d_q;
    r_d       = r_q;
    rotates_d = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (clr_i) begin
      state_d   = ST_EMPTY;
      cnt_d     = '0;
      row_cnt_d = '0;
      x_ff_d    = '0;
      y_ff_d    = '0;
      d_d       = '0;
      r_d       = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (valid_i) begin
            x_ff_d    = x_i;
            row_cnt_d = ROW_W'(1);
            state_d   = ST_READY;
          end
        end
        ST_READY, ST_ROT: begin
          if (state_q == ST_ROT || valid_i) begin
            x_ff_d    = rot_x;
            y_ff_d    = rot_y;
            d_d       = rot_d;
            rotates_d = 1'b1;
            valid_d   = (state_q == ST_READY);
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_SCALE;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_ROT;
            end
          end
        end
        ST_SCALE: begin
          x_ff_d    = scaled;
          r_d       = scaled;
          y_ff_d    = '0;
          row_cnt_d = row_inc;
          if (row_inc == ROW_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      row_cnt_q <= '0;
      x_ff_q    <= '0;
      y_ff_q    <= '0;
      d_q       <= '0;
      rotates_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_cnt_q <= row_cnt_d;
      x_ff_q    <= x_ff_d;
      y_ff_q    <= y_ff_d;
      d_q       <= d_d;
      rotates_q <= rotates_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      r_q       <= r_d;
    end
  end

  assign d_o       = d_q;
  assign rotates_o = rotates_q;
  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign r_o       = r_q;
  assign busy_o    = (state_q == ST_ROT) || (state_q == ST_SCALE);

`ifdef GG_OVF_FLAG_EN
  logic err_q, err_d;

  // Sticky overrun: any sample offered while the cell cannot take it.
  always_comb begin
    err_d = err_q;
    if (clr_i) begin
      err_d = 1'b0;
    end else if (valid_i && (busy_o || state_q == ST_DONE)) begin
      err_d = 1'b1;
    end
  end

  // Overrun flag register, cleared only by rst or clr_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gg_cell.sv
// tb_gg_cell: directed bench for gg_cell with two instances (ROWS=2 and ROWS=4).
module tb_gg_cell;

  localparam int DW  = 20;
  localparam int D_W = 4;

`ifdef GG_OVF_FLAG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with ROWS=2 ----------------
  logic signed [DW-1:0] x2, r2;
  logic                 v2, c2, rot2, vo2, done2, busy2, err2;
  logic [D_W-1:0]       d2;

  gg_cell #(.D_WIDTH(D_W), .DATA_WIDTH(DW), .ROWS(2)) dut2 (
    .clk(clk), .rst(rst), .x_i(x2), .valid_i(v2), .clr_i(c2),
    .d_o(d2), .rotates_o(rot2), .valid_o(vo2), .r_o(r2),
    .done_o(done2), .busy_o(busy2), .err_o(err2)
  );

  // ---------------- DUT with ROWS=4 ----------------
  logic signed [DW-1:0] x4, r4;
  logic                 v4, c4, rot4, vo4, done4, busy4, err4;
  logic [D_W-1:0]       d4;

  gg_cell #(.D_WIDTH(D_W), .DATA_WIDTH(DW), .ROWS(4)) dut4 (
    .clk(clk), .rst(rst), .x_i(x4), .valid_i(v4), .clr_i(c4),
    .d_o(d4), .rotates_o(rot4), .valid_o(vo4), .r_o(r4),
    .done_o(done4), .busy_o(busy4), .err_o(err4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_max(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream rotation cell: replays the 12 direction bits on (x, y).
  function automatic int replay_y(input int x0, input int y0, input logic [11:0] dirs);
    int x, y, xn;
    x = x0;
    y = y0;
    for (int s = 0; s < 12; s++) begin
      if (dirs[s]) begin
        xn = x - (y >>> s);
        y  = y + (x >>> s);
      end else begin
        xn = x + (y >>> s);
        y  = y - (x >>> s);
      end
      x = xn;
    end
    return y;
  endfunction

  // Reference vectoring CORDIC: directions chosen from signs, 12 iterations.
  function automatic int cordic_x(input int x0, input int y0);
    int x, y, xn;
    x = x0;
    y = y0;
    for (int s = 0; s < 12; s++) begin
      if ((x < 0) != (y < 0)) begin
        xn = x - (y >>> s);
        y  = y + (x >>> s);
      end else begin
        xn = x + (y >>> s);
        y  = y - (x >>> s);
      end
      x = xn;
    end
    return x;
  endfunction

  function automatic int k_scale(input int x);
    return (x * 621) >>> 10;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic signed [DW-1:0] x0;
    logic signed [DW-1:0] y1;
    logic [D_W-1:0]       g0;
    logic [D_W-1:0]       g1;
    logic [D_W-1:0]       g2;
    int                   r;
  } vec_t;

  vec_t vecs[3];

  // Clear, load x0, rotate y1, then walk the T+1..T+5 timeline.
  task automatic apply_vec(input vec_t v, input int idx, output logic [11:0] dirs);
    c2 = 1'b1;
    tick();
    c2 = 1'b0;
    chk($sformatf("v%0d_clr_r", idx), r2, 0);
    chk($sformatf("v%0d_clr_busy", idx), busy2, 0);
    x2 = v.x0;
    v2 = 1'b1;
    tick();
    chk($sformatf("v%0d_load_no_valid", idx), vo2, 0);
    x2 = v.y1;
    tick();
    v2 = 1'b0;
    x2 = '0;
    chk($sformatf("v%0d_t1_valid", idx), vo2, 1);
    chk($sformatf("v%0d_t1_rot", idx), rot2, 1);
    chk($sformatf("v%0d_t1_d", idx), d2, v.g0);
    chk($sformatf("v%0d_t1_busy", idx), busy2, 1);
    dirs[3:0] = d2;
    tick();
    chk($sformatf("v%0d_t2_valid", idx), vo2, 0);
    chk($sformatf("v%0d_t2_rot", idx), rot2, 1);
    chk($sformatf("v%0d_t2_d", idx), d2, v.g1);
    dirs[7:4] = d2;
    tick();
    chk($sformatf("v%0d_t3_rot", idx), rot2, 1);
    chk($sformatf("v%0d_t3_d", idx), d2, v.g2);
    chk($sformatf("v%0d_t3_busy", idx), busy2, 1);
    chk($sformatf("v%0d_t3_done", idx), done2, 0);
    dirs[11:8] = d2;
    tick();
    chk($sformatf("v%0d_t4_rot", idx), rot2, 0);
    chk($sformatf("v%0d_t4_r", idx), r2, v.r);
    chk($sformatf("v%0d_t4_done", idx), done2, 1);
    chk($sformatf("v%0d_t4_busy", idx), busy2, 0);
    chk($sformatf("v%0d_t4_d_hold", idx), d2, v.g2);
    tick();
    chk($sformatf("v%0d_t5_done_pulse", idx), done2, 0);
    chk($sformatf("v%0d_t5_r_hold", idx), r2, v.r);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [11:0] dirs;
    int          ry;
    int          nv, nd, exp_col;
    int          col[4];

    // Hand-computed: 12 micro-rotations at 20-bit arithmetic, then *621>>>10.
    vecs[0] = '{x0: DW'(3072),  y1: DW'(4096), g0: 4'hC, g1: 4'h2, g2: 4'hF, r: 5115};
    vecs[1] = '{x0: DW'(-3072), y1: DW'(4096), g0: 4'h3, g1: 4'hD, g2: 4'h8, r: -5115};
    vecs[2] = '{x0: DW'(4096),  y1: DW'(0),    g0: 4'hE, g1: 4'h2, g2: 4'hF, r: 4092};

    rst = 1'b1;
    x2 = '0; v2 = 1'b0; c2 = 1'b0;
    x4 = '0; v4 = 1'b0; c4 = 1'b0;
    dirs = '0;
    #22;
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_r2", r2, 0);
    chk("rst_d2", d2, 0);
    chk("rst_valid2", vo2, 0);
    chk("rst_rot2", rot2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_err2", err2, 0);
    chk("rst_r4", r4, 0);
    chk("rst_busy4", busy4, 0);

    // Table-driven rotations on the ROWS=2 instance
    for (int i = 0; i < 3; i++) begin
      apply_vec(vecs[i], i, dirs);
      if (i == 0) begin
        ry = replay_y(3072, 4096, dirs);
        if (ry < 0) ry = -ry;
        chk_max("replay_y_abs", ry, 4);
      end
    end

    // DONE ignores valid_i; clr_i returns to EMPTY with r_o cleared
    x2 = DW'(999);
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    chk("done_ignore_r", r2, vecs[2].r);
    chk("done_ignore_valid", vo2, 0);
    chk("done_ignore_busy", busy2, 0);
    chk("done_err", err2, EXP_ERR);
    c2 = 1'b1;
    tick();
    c2 = 1'b0;
    chk("clr_done_r", r2, 0);
    chk("clr_done_err", err2, 0);
    chk("clr_done_d", d2, 0);
    x2 = DW'(3072);
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    chk("empty_load_valid", vo2, 0);
    chk("empty_load_rot", rot2, 0);
    chk("empty_load_busy", busy2, 0);

    // Overrun: a sample offered mid-rotation is dropped
    c2 = 1'b1;
    tick();
    c2 = 1'b0;
    x2 = DW'(3072);
    v2 = 1'b1;
    tick();
    x2 = DW'(4096);
    tick();
    v2 = 1'b0;
    chk("ovr_t1_d", d2, 4'hC);
    tick();
    chk("ovr_t2_err", err2, 0);
    x2 = DW'(12345);
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    chk("ovr_t3_d", d2, 4'hF);
    chk("ovr_t3_err", err2, EXP_ERR);
    tick();
    chk("ovr_t4_r", r2, 5115);
    chk("ovr_t4_done", done2, 1);
    chk("ovr_t4_err", err2, EXP_ERR);
    tick();
    chk("ovr_t5_err", err2, EXP_ERR);
    chk("ovr_t5_r", r2, 5115);

    // Asynchronous reset in the middle of a second rotation (ROWS=4)
    c4 = 1'b1;
    tick();
    c4 = 1'b0;
    x4 = DW'(3072);
    v4 = 1'b1;
    tick();
    x4 = DW'(4096);
    tick();
    v4 = 1'b0;
    tick();
    tick();
    tick();
    chk("r4_first_rot", r4, 5115);
    chk("r4_first_done", done4, 0);
    chk("r4_ready_busy", busy4, 0);
    x4 = DW'(1024);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("r4_second_valid", vo4, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", vo4, 0);
    chk("arst_rot", rot4, 0);
    chk("arst_d", d4, 0);
    chk("arst_r", r4, 0);
    chk("arst_done", done4, 0);
    chk("arst_busy", busy4, 0);
    rst = 1'b0;
    tick();
    chk("arst_after_valid", vo4, 0);
    chk("arst_after_busy", busy4, 0);

    // Full column on ROWS=4: samples 1.0, 2.0, 2.0, 0.0 spaced 4 cycles
    col[0] = 1024;
    col[1] = 2048;
    col[2] = 2048;
    col[3] = 0;
    exp_col = col[0];
    for (int i = 1; i < 4; i++) begin
      exp_col = k_scale(cordic_x(exp_col, col[i]));
    end
    nv = 0;
    nd = 0;
    c4 = 1'b1;
    tick();
    c4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x4 = DW'(col[i]);
      v4 = 1'b1;
      tick();
      v4 = 1'b0;
      nv += int'(vo4);
      nd += int'(done4);
      for (int j = 0; j < 3; j++) begin
        tick();
        nv += int'(vo4);
        nd += int'(done4);
      end
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      nv += int'(vo4);
      nd += int'(done4);
    end
    chk("col_valid_count", nv, 3);
    chk("col_done_count", nd, 1);
    chk("col_r", r4, exp_col);
    chk("col_err", err4, 0);
    chk("col_busy", busy4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total run time.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
